// File: rtl/sddt_instr_pkg.sv
// Instruction-slot encoding shared by the AXI-Stream command decoder:
// opcode values, slot width, flag bit positions and the opcode decode helper.
package sddt_instr_pkg;

    localparam int unsigned SLOT_W      = 32;
    localparam int unsigned OP_W        = 3;
    localparam int unsigned PALL_BIT    = 28;
    localparam int unsigned AP_BIT      = 29;
    localparam int unsigned HALF_BL_BIT = 30;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpPre = 3'd1,
        OpAct = 3'd2,
        OpRd  = 3'd3,
        OpWr  = 3'd4,
        OpRef = 3'd5,
        OpZq  = 3'd6,
        OpIll = 3'd7
    } opcode_e;

    typedef struct packed {
        logic nop;
        logic pre;
        logic act;
        logic rd;
        logic wr;
        logic refresh;
        logic zq;
        logic illegal;
    } op_flags_t;

    // The undefined opcode still yields a NOP so every slot carries exactly one command.
    function automatic op_flags_t decode_op(input logic [OP_W-1:0] op);
        op_flags_t f;
        f = '0;
        case (opcode_e'(op))
            OpNop:   f.nop     = 1'b1;
            OpPre:   f.pre     = 1'b1;
            OpAct:   f.act     = 1'b1;
            OpRd:    f.rd      = 1'b1;
            OpWr:    f.wr      = 1'b1;
            OpRef:   f.refresh = 1'b1;
            OpZq:    f.zq      = 1'b1;
            default: begin
                f.nop     = 1'b1;
                f.illegal = 1'b1;
            end
        endcase
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high flush; no fall-through,
// a beat written this cycle becomes readable on the next one.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem[rd_ptr_q];

    // A full FIFO refuses the write even when a pop frees a slot in the same cycle.
    assign do_push = push && !full && !rst;
    assign do_pop  = pop && !empty && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/axis_cmd_decoder.sv
// Buffers AXI-Stream instruction beats and decodes one beat per issue_en into per-slot DDR
// command flags and address fields. Define AXIS_CMD_DECODER_STATS_EN to build the statistics counters.
module axis_cmd_decoder
    import sddt_instr_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned BG_WIDTH   = 2,
    parameter int unsigned BANK_WIDTH = 2,
    parameter int unsigned COL_WIDTH  = 10,
    parameter int unsigned ROW_WIDTH  = 17
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SLOT_W*NUM_SLOTS-1:0]     S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic                            issue_en,
    output logic [NUM_SLOTS-1:0]            ddr_write,
    output logic [NUM_SLOTS-1:0]            ddr_read,
    output logic [NUM_SLOTS-1:0]            ddr_pre,
    output logic [NUM_SLOTS-1:0]            ddr_act,
    output logic [NUM_SLOTS-1:0]            ddr_ref,
    output logic [NUM_SLOTS-1:0]            ddr_zq,
    output logic [NUM_SLOTS-1:0]            ddr_nop,
    output logic [NUM_SLOTS-1:0]            ddr_ap,
    output logic [NUM_SLOTS-1:0]            ddr_half_bl,
    output logic [NUM_SLOTS-1:0]            ddr_pall,
    output logic [NUM_SLOTS*BG_WIDTH-1:0]   ddr_bg,
    output logic [NUM_SLOTS*BANK_WIDTH-1:0] ddr_bank,
    output logic [NUM_SLOTS*COL_WIDTH-1:0]  ddr_col,
    output logic [NUM_SLOTS*ROW_WIDTH-1:0]  ddr_row,
    output logic [$clog2(DEPTH):0]          fifo_level,
    output logic                            underflow,
    output logic                            illegal_op,
    output logic [31:0]                     issued_cnt,
    output logic [31:0]                     underflow_cnt
);

    localparam int unsigned BEAT_W   = SLOT_W * NUM_SLOTS;
    localparam int unsigned BANK_LSB = OP_W;
    localparam int unsigned BG_LSB   = OP_W + BANK_WIDTH;
    localparam int unsigned ADDR_LSB = OP_W + BANK_WIDTH + BG_WIDTH;

    typedef struct packed {
        logic [NUM_SLOTS-1:0]            write;
        logic [NUM_SLOTS-1:0]            read;
        logic [NUM_SLOTS-1:0]            pre;
        logic [NUM_SLOTS-1:0]            act;
        logic [NUM_SLOTS-1:0]            refresh;
        logic [NUM_SLOTS-1:0]            zq;
        logic [NUM_SLOTS-1:0]            nop;
        logic [NUM_SLOTS-1:0]            ap;
        logic [NUM_SLOTS-1:0]            half_bl;
        logic [NUM_SLOTS-1:0]            pall;
        logic [NUM_SLOTS*BG_WIDTH-1:0]   bg;
        logic [NUM_SLOTS*BANK_WIDTH-1:0] bank;
        logic [NUM_SLOTS*COL_WIDTH-1:0]  col;
        logic [NUM_SLOTS*ROW_WIDTH-1:0]  row;
    } cmd_t;

    logic [BEAT_W-1:0]      head;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] level;
    logic                   push, pop_ok, empty_issue, ill_hit;
    logic                   underflow_q, illegal_q;
    logic                   unused_rsvd;
    op_flags_t              flags;
    cmd_t                   cmd_d, cmd_q, cmd_out;

    assign S_AXIS_TREADY = !rst && !fifo_full;
    assign push          = S_AXIS_TVALID && S_AXIS_TREADY;
    assign pop_ok        = issue_en && !fifo_empty;
    assign empty_issue   = issue_en && fifo_empty;

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (S_AXIS_TDATA),
        .pop   (issue_en),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // Reserved bit 31 and any gap above the address fields are ignored by design.
    assign unused_rsvd = ^head;

    always_comb begin
        cmd_d     = '0;
        cmd_d.nop = '1;
        ill_hit   = 1'b0;
        flags     = '0;
        if (pop_ok) begin
            cmd_d.nop = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                flags                = decode_op(head[i*SLOT_W +: OP_W]);
                cmd_d.nop[i]         = flags.nop;
                cmd_d.pre[i]         = flags.pre;
                cmd_d.act[i]         = flags.act;
                cmd_d.read[i]        = flags.rd;
                cmd_d.write[i]       = flags.wr;
                cmd_d.refresh[i]     = flags.refresh;
                cmd_d.zq[i]          = flags.zq;
                cmd_d.pall[i]        = head[i*SLOT_W + PALL_BIT];
                cmd_d.ap[i]          = head[i*SLOT_W + AP_BIT];
                cmd_d.half_bl[i]     = head[i*SLOT_W + HALF_BL_BIT];
                cmd_d.bank[i*BANK_WIDTH +: BANK_WIDTH] = head[i*SLOT_W + BANK_LSB +: BANK_WIDTH];
                cmd_d.bg[i*BG_WIDTH +: BG_WIDTH]       = head[i*SLOT_W + BG_LSB +: BG_WIDTH];
                cmd_d.row[i*ROW_WIDTH +: ROW_WIDTH]    = head[i*SLOT_W + ADDR_LSB +: ROW_WIDTH];
                cmd_d.col[i*COL_WIDTH +: COL_WIDTH]    = head[i*SLOT_W + ADDR_LSB +: COL_WIDTH];
                ill_hit              = ill_hit | flags.illegal;
            end
        end
    end

    // Registers rest at all-NOP so the first cycle after reset already carries one command
    // per slot; the all-zero reset picture comes from the output gating below.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q       <= '0;
            cmd_q.nop   <= '1;
            underflow_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            cmd_q <= cmd_d;
            if (empty_issue) begin
                underflow_q <= 1'b1;
            end
            if (ill_hit) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cmd_out = rst ? '0 : cmd_q;
    end

    assign ddr_write   = cmd_out.write;
    assign ddr_read    = cmd_out.read;
    assign ddr_pre     = cmd_out.pre;
    assign ddr_act     = cmd_out.act;
    assign ddr_ref     = cmd_out.refresh;
    assign ddr_zq      = cmd_out.zq;
    assign ddr_nop     = cmd_out.nop;
    assign ddr_ap      = cmd_out.ap;
    assign ddr_half_bl = cmd_out.half_bl;
    assign ddr_pall    = cmd_out.pall;
    assign ddr_bg      = cmd_out.bg;
    assign ddr_bank    = cmd_out.bank;
    assign ddr_col     = cmd_out.col;
    assign ddr_row     = cmd_out.row;
    assign fifo_level  = rst ? '0 : level;
    assign underflow   = underflow_q && !rst;
    assign illegal_op  = illegal_q && !rst;

`ifdef AXIS_CMD_DECODER_STATS_EN
    logic [31:0] issued_q, underflow_cnt_q;

    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q        <= '0;
            underflow_cnt_q <= '0;
        end else begin
            if (pop_ok && (issued_q != '1)) begin
                issued_q <= issued_q + 32'd1;
            end
            if (empty_issue && (underflow_cnt_q != '1)) begin
                underflow_cnt_q <= underflow_cnt_q + 32'd1;
            end
        end
    end

    assign issued_cnt    = rst ? '0 : issued_q;
    assign underflow_cnt = rst ? '0 : underflow_cnt_q;
`else
    assign issued_cnt    = '0;
    assign underflow_cnt = '0;
`endif

endmodule
